mem_arbiter: RTL and testbench

//  Shares the single word-wide main-memory port between the instruction cache (refill bursts)
//  and the data cache (reads/writes). Sits between both caches and memory. Grants one owner at
//  a time, locks the grant across a multi-beat burst, and can preempt a long burst at a beat

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state codes (equal to the o_grant encoding)
// and owner identifiers used for tie-breaking.
`timescale 1ns/1ps
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  function automatic arb_state_t grant_of(owner_t o);
    return (o == OWNER_D) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner select for an IDLE arbitration round.
// ARB_ROUND_ROBIN_EN defined: ties go to the requester that did not own the port last.
`timescale 1ns/1ps
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
  input  owner_t last_owner,
  output owner_t winner
);

  always_comb begin
    winner = OWNER_D;
    if (ic_req && !dc_req) begin
      winner = OWNER_I;
    end else if (ic_req && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
`else
      winner = OWNER_D;
`endif
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between ICache and DCache; locks the grant across bursts and
// preempts after MAX_BURST beats. Optional ARB_ROUND_ROBIN_EN selects round-robin ties.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MAX_BURST      = 16,
  parameter int BEAT_CNT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ic_req,
  input  logic [ADDRESS_WIDTH-1:0] ic_addr,
  output logic                     ic_ack,
  output logic [DATA_WIDTH-1:0]    ic_rdata,
  input  logic                     dc_req,
  input  logic                     dc_we,
  input  logic [ADDRESS_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0]    dc_wdata,
  output logic                     dc_ack,
  output logic [DATA_WIDTH-1:0]    dc_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [1:0]               o_grant
);

  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_LAST = BEAT_CNT_WIDTH'(MAX_BURST - 1);

  arb_state_t                state, state_nxt, other;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
  owner_t                    last_owner, winner;
  logic                      own_req, oth_req, burst_full;

  mem_arbiter_pick u_pick (
    .ic_req     (ic_req),
    .dc_req     (dc_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  assign burst_full = (beat_cnt == BEAT_LAST);

  always_comb begin
    other   = (state == GRANT_I) ? GRANT_D : GRANT_I;
    own_req = (state == GRANT_I) ? ic_req : dc_req;
    oth_req = (state == GRANT_I) ? dc_req : ic_req;
  end

  // Owner changes only at a beat boundary: its req is low (nothing in flight) or an ack lands.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (ic_req || dc_req) state_nxt = grant_of(winner);
      end
      GRANT_I, GRANT_D: begin
        if (!own_req)                              state_nxt = oth_req ? other : IDLE;
        else if (mem_ack && burst_full && oth_req) state_nxt = other;
        else if (mem_ack && !burst_full)           beat_cnt_nxt = beat_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) beat_cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_owner <= OWNER_I;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (state_nxt != state && state_nxt != IDLE)
        last_owner <= (state_nxt == GRANT_D) ? OWNER_D : OWNER_I;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ic_ack    = 1'b0;
    ic_rdata  = '0;
    dc_ack    = 1'b0;
    dc_rdata  = '0;
    case (state)
      GRANT_I: begin
        mem_req  = ic_req;
        mem_addr = ic_addr;
        ic_ack   = mem_ack;
        ic_rdata = mem_rdata;
      end
      GRANT_D: begin
        mem_req   = dc_req;
        mem_we    = dc_we;
        mem_addr  = dc_addr;
        mem_wdata = dc_wdata;
        dc_ack    = mem_ack;
        dc_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

  assign o_grant = state;

`ifndef SYNTHESIS
  // Requesters must hold req and payload steady until acked.
  ic_hold: assert property (@(posedge clk) disable iff (rst)
    (ic_req && !ic_ack) |=> (ic_req && $stable(ic_addr)));
  dc_hold: assert property (@(posedge clk) disable iff (rst)
    (dc_req && !dc_ack) |=> (dc_req && $stable({dc_we, dc_addr, dc_wdata})));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (MAX_BURST=4): cache/memory models with a scoreboard plus
// table-driven DCache ops and hand-written tie, preempt, handover and reset sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4;
  localparam int BW = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0] TIE_GRANT = 2'b01;
`else
  localparam logic [1:0] TIE_GRANT = 2'b10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_req = 1'b0, ic_ack;
  logic [AW-1:0] ic_addr = '0;
  logic [DW-1:0] ic_rdata;
  logic dc_req = 1'b0, dc_we = 1'b0, dc_ack;
  logic [AW-1:0] dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0, dc_rdata;
  logic mem_req, mem_we, mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic [1:0] o_grant;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB), .BEAT_CNT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } dc_op_t;

  int checks = 0;
  int errors = 0;

  // Cache / memory model state
  int            ic_todo = 0, ic_done = 0;
  logic [AW-1:0] ic_base = '0;
  logic [AW-1:0] ic_q[$];
  dc_op_t        dc_q[$];
  int            ic_acks = 0, dc_acks = 0, ic_acks_at_dc = 0, bubbles = 0, mem_wait = 0;
  logic          ic_ack_s = 1'b0, dc_ack_s = 1'b0;
  logic [1:0]    grant_prev = 2'b00;

  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Environment: observe at negedge, drive caches at posedge+1, memory at posedge+2.
  initial begin
    logic [AW-1:0] a;
    dc_op_t        op;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ic_ack) begin
          ic_acks++;
          chk("ic_ack_expected", 64'(ic_q.size() > 0), 1);
          if (ic_q.size() > 0) begin
            a = ic_q.pop_front();
            chk("ic_rdata", ic_rdata, mem_word(a));
            chk("ic_mem_addr", mem_addr, a);
            chk("ic_mem_we", mem_we, 0);
            chk("ic_beat_dc_ack", dc_ack, 0);
          end
        end
        if (dc_ack) begin
          dc_acks++;
          ic_acks_at_dc = ic_acks;
          chk("dc_ack_expected", 64'(dc_q.size() > 0), 1);
          chk("dc_ack_with_mem_ack", mem_ack, 1);
          chk("dc_beat_ic_ack", ic_ack, 0);
          if (dc_q.size() > 0) begin
            op = dc_q.pop_front();
            chk("dc_mem_addr", mem_addr, op.addr);
            chk("dc_mem_we", mem_we, op.we);
            if (op.we) chk("dc_mem_wdata", mem_wdata, op.wdata);
            else       chk("dc_rdata", dc_rdata, op.exp_rdata);
          end
        end
        if (o_grant == 2'b00 && grant_prev != 2'b00 && (ic_req || dc_req)) bubbles++;
        grant_prev = o_grant;
      end
      ic_ack_s = ic_ack;
      dc_ack_s = dc_ack;
      @(posedge clk);
      #1;
      if (rst) begin
        ic_req = 1'b0; ic_todo = 0; ic_q.delete();
        dc_req = 1'b0; dc_q.delete();
        mem_ack = 1'b0; mem_wait = 0;
        ic_ack_s = 1'b0; dc_ack_s = 1'b0; grant_prev = 2'b00;
      end else begin
        if (ic_ack_s) ic_req = 1'b0;
        if (!ic_req && ic_todo > 0) begin
          ic_req  = 1'b1;
          ic_addr = ic_base + AW'(ic_done);
          ic_q.push_back(ic_addr);
          ic_done++;
          ic_todo--;
        end
        if (dc_ack_s) dc_req = 1'b0;
        if (!dc_req && dc_q.size() > 0) begin
          dc_req   = 1'b1;
          dc_we    = dc_q[0].we;
          dc_addr  = dc_q[0].addr;
          dc_wdata = dc_q[0].wdata;
        end
        #1;
        if (mem_ack) begin
          mem_ack = 1'b0;
          mem_wait = 0;
        end else if (mem_req) begin
          if (mem_wait >= 1) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
          end else begin
            mem_wait++;
          end
        end
      end
    end
  end

  task automatic wait_idle(string name);
    int n = 0;
    while ((ic_todo > 0 || ic_req || dc_q.size() > 0 || o_grant != 2'b00) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 500), 1);
  endtask

  task automatic wait_grant(string name, logic [1:0] g);
    int n = 0;
    do begin @(negedge clk); n++; end while (o_grant != g && n < 200);
    chk(name, o_grant, g);
  endtask

  task automatic wait_ic_ack(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ic_ack && n < 200);
    chk(name, ic_ack, 1);
  endtask

  task automatic wait_dc_ack(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!dc_ack && n < 200);
    chk(name, dc_ack, 1);
  endtask

  initial begin
    dc_op_t tbl[4];
    int ic0, dc0;
    tbl[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0104, 32'h0,         32'h5A5A_0104};
    tbl[2] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0};
    tbl[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_FFFC};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_grant", o_grant, 2'b00);
    chk("reset_outs", {mem_req, mem_we, ic_ack, dc_ack}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_grant", o_grant, 2'b00);
    chk("idle_mem_req", mem_req, 0);

    // ICache-only burst of 16 beats
    ic0 = ic_acks; dc0 = dc_acks;
    ic_base = 32'h0000_0400; ic_done = 0; ic_todo = 16;
    @(negedge clk);
    chk("ic_arb_wait", o_grant, 2'b00);
    @(negedge clk);
    chk("ic_grant_latency", o_grant, 2'b01);
    wait_idle("ic_burst_done");
    chk("ic_burst_acks", ic_acks - ic0, 16);
    chk("ic_burst_no_dc_ack", dc_acks - dc0, 0);

    // DCache ops from the table
    for (int i = 0; i < 4; i++) begin
      dc0 = dc_acks;
      dc_q.push_back(tbl[i]);
      wait_idle("tbl_done");
      chk("tbl_dc_acks", dc_acks - dc0, 1);
    end

    // Tie in IDLE (last owner is DCache)
    dc_q.push_back(tbl[1]);
    ic_base = 32'h0000_0800; ic_done = 0; ic_todo = 1;
    @(negedge clk);
    chk("tie_wait", o_grant, 2'b00);
    @(negedge clk);
    chk("tie_grant", o_grant, TIE_GRANT);
    wait_idle("tie_done");

    // Preemption after MAX_BURST beats
    ic0 = ic_acks;
    ic_base = 32'h0000_1000; ic_done = 0; ic_todo = 8;
    wait_ic_ack("pre_beat1");
    dc_q.push_back(tbl[3]);
    repeat (3) wait_ic_ack("pre_beat");
    @(negedge clk);
    chk("preempt_grant", o_grant, 2'b10);
    wait_idle("preempt_done");
    chk("preempt_after_beats", ic_acks_at_dc - ic0, 4);
    chk("preempt_total_ic", ic_acks - ic0, 8);

    // Handover DCache -> ICache without idle
    dc_q.push_back(tbl[2]);
    wait_grant("ho_dc_grant", 2'b10);
    ic_base = 32'h0000_2000; ic_done = 0; ic_todo = 2;
    wait_dc_ack("ho_dc_ack");
    @(negedge clk);
    chk("ho_hold", o_grant, 2'b10);
    @(negedge clk);
    chk("ho_switch", o_grant, 2'b01);
    wait_idle("ho_done");

    // Reset mid-burst, then restart
    ic_base = 32'h0000_3000; ic_done = 0; ic_todo = 6;
    wait_ic_ack("rst_pre_ack");
    #2 rst = 1'b1;
    #1;
    chk("rst_async_grant", o_grant, 2'b00);
    chk("rst_async_outs", {mem_req, mem_we, ic_ack, dc_ack}, 0);
    chk("rst_async_rdata", ic_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", o_grant, 2'b00);
    chk("post_rst_mem_req", mem_req, 0);
    ic0 = ic_acks;
    ic_base = 32'h0000_3000; ic_done = 0; ic_todo = 2;
    wait_idle("restart_done");
    chk("restart_acks", ic_acks - ic0, 2);

    chk("no_bubbles", bubbles, 0);
    chk("queues_drained", ic_q.size() + dc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

endmodule
